// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared register-file and operand types for the rename stage
package rv32i_types;

  localparam int ARCH_REG_W = 5;
  localparam int ROB_TAG_W  = 4;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [XLEN-1:0]      value;
    logic [ROB_TAG_W-1:0] tag;
    logic                 busy;
  } rf_entry_t;

  typedef struct packed {
    logic [XLEN-1:0]      value;
    logic [ROB_TAG_W-1:0] tag;
    logic                 ready;
  } operand_t;

endpackage

// File: rtl/rename_operand_lookup.sv
// rtl/rename_operand_lookup.sv - resolves one source operand against x0, older dispatch slots, commit bypass and the entry
module rename_operand_lookup
  import rv32i_types::*;
#(
  parameter int RIDX_W   = 5,
  parameter int TAG_W    = 4,
  parameter int DATA_W   = 32,
  parameter int DISP_W   = 2,
  parameter int COMMIT_W = 2
) (
  input  logic [RIDX_W-1:0]          src,
  input  rf_entry_t                  entry,
  input  logic [DISP_W-1:0]          older_valid,
  input  logic [DISP_W*RIDX_W-1:0]   disp_rd,
  input  logic [DISP_W*TAG_W-1:0]    disp_tag,
  input  logic [COMMIT_W-1:0]        commit_valid,
  input  logic [COMMIT_W*RIDX_W-1:0] commit_rd,
  input  logic [COMMIT_W*TAG_W-1:0]  commit_tag,
  input  logic [COMMIT_W*DATA_W-1:0] commit_value,
  output operand_t                   opnd
);

  logic              fwd_hit;
  logic [TAG_W-1:0]  fwd_tag;
  logic              byp_hit;
  logic [DATA_W-1:0] byp_value;

  always_comb begin
    fwd_hit   = 1'b0;
    fwd_tag   = '0;
    byp_hit   = 1'b0;
    byp_value = '0;
    // later slots overwrite earlier ones, so the youngest older producer wins
    for (int j = 0; j < DISP_W; j++) begin
      if (older_valid[j] && disp_rd[j*RIDX_W +: RIDX_W] == src) begin
        fwd_hit = 1'b1;
        fwd_tag = disp_tag[j*TAG_W +: TAG_W];
      end
    end
    for (int k = 0; k < COMMIT_W; k++) begin
      if (commit_valid[k] && commit_rd[k*RIDX_W +: RIDX_W] == src &&
          commit_tag[k*TAG_W +: TAG_W] == entry.tag) begin
        byp_hit   = 1'b1;
        byp_value = commit_value[k*DATA_W +: DATA_W];
      end
    end

    opnd = '0;
    if (src == '0) begin
      opnd.ready = 1'b1;
    end else if (fwd_hit) begin
      opnd.tag = fwd_tag;
    end else if (entry.busy && byp_hit) begin
      opnd.ready = 1'b1;
      opnd.value = byp_value;
    end else if (entry.busy) begin
      opnd.tag = entry.tag;
    end else begin
      opnd.ready = 1'b1;
      opnd.value = entry.value;
    end
  end

endmodule

// File: rtl/rename_regfile_mp.sv
// rtl/rename_regfile_mp.sv - multi-port architectural register file with ROB rename tags
module rename_regfile_mp
  import rv32i_types::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int DATA_W    = 32,
  parameter int ROB_DEPTH = 16,
  parameter int DISP_W    = 2,
  parameter int COMMIT_W  = 2,
  localparam int RIDX_W   = $clog2(NUM_REGS),
  localparam int TAG_W    = $clog2(ROB_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [DISP_W-1:0]          disp_valid,
  input  logic [DISP_W*RIDX_W-1:0]   disp_rs1,
  input  logic [DISP_W*RIDX_W-1:0]   disp_rs2,
  input  logic [DISP_W*RIDX_W-1:0]   disp_rd,
  input  logic [DISP_W*TAG_W-1:0]    disp_tag,
  output logic [DISP_W-1:0]          rs1_ready,
  output logic [DISP_W-1:0]          rs2_ready,
  output logic [DISP_W*DATA_W-1:0]   rs1_value,
  output logic [DISP_W*DATA_W-1:0]   rs2_value,
  output logic [DISP_W*TAG_W-1:0]    rs1_tag,
  output logic [DISP_W*TAG_W-1:0]    rs2_tag,
  input  logic [COMMIT_W-1:0]        commit_valid,
  input  logic [COMMIT_W*RIDX_W-1:0] commit_rd,
  input  logic [COMMIT_W*TAG_W-1:0]  commit_tag,
  input  logic [COMMIT_W*DATA_W-1:0] commit_value,
  output logic [RIDX_W:0]            busy_count
);

  rf_entry_t           regs     [NUM_REGS];
  rf_entry_t           regs_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] renamed;
  logic [RIDX_W:0]     count_nxt;

  always_comb begin
    renamed = '0;
    for (int i = 0; i < DISP_W; i++) begin
      if (disp_valid[i] && disp_rd[i*RIDX_W +: RIDX_W] != '0)
        renamed[disp_rd[i*RIDX_W +: RIDX_W]] = 1'b1;
    end

    for (int r = 0; r < NUM_REGS; r++)
      regs_nxt[r] = regs[r];

    // commit: value always lands; busy drops only for the current producer not re-renamed this cycle
    for (int k = 0; k < COMMIT_W; k++) begin
      if (commit_valid[k] && commit_rd[k*RIDX_W +: RIDX_W] != '0) begin
        regs_nxt[commit_rd[k*RIDX_W +: RIDX_W]].value = commit_value[k*DATA_W +: DATA_W];
        if (regs[commit_rd[k*RIDX_W +: RIDX_W]].tag == commit_tag[k*TAG_W +: TAG_W] &&
            !renamed[commit_rd[k*RIDX_W +: RIDX_W]])
          regs_nxt[commit_rd[k*RIDX_W +: RIDX_W]].busy = 1'b0;
      end
    end

    if (flush) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_nxt[r].busy = 1'b0;
        regs_nxt[r].tag  = '0;
      end
    end else begin
      for (int i = 0; i < DISP_W; i++) begin
        if (disp_valid[i] && disp_rd[i*RIDX_W +: RIDX_W] != '0) begin
          regs_nxt[disp_rd[i*RIDX_W +: RIDX_W]].tag  = disp_tag[i*TAG_W +: TAG_W];
          regs_nxt[disp_rd[i*RIDX_W +: RIDX_W]].busy = 1'b1;
        end
      end
    end

    regs_nxt[0] = '0;

    count_nxt = '0;
    for (int r = 0; r < NUM_REGS; r++)
      count_nxt = count_nxt + {{RIDX_W{1'b0}}, regs_nxt[r].busy};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++)
        regs[r] <= '0;
      busy_count <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        regs[r] <= regs_nxt[r];
      busy_count <= count_nxt;
    end
  end

  for (genvar i = 0; i < DISP_W; i++) begin : g_slot
    localparam logic [DISP_W-1:0] OLDER_MASK = DISP_W'((1 << i) - 1);
    logic [DISP_W-1:0] older_valid;
    operand_t          op1;
    operand_t          op2;

    assign older_valid = disp_valid & OLDER_MASK;

    rename_operand_lookup #(
      .RIDX_W(RIDX_W), .TAG_W(TAG_W), .DATA_W(DATA_W),
      .DISP_W(DISP_W), .COMMIT_W(COMMIT_W)
    ) u_rs1 (
      .src(disp_rs1[i*RIDX_W +: RIDX_W]), .entry(regs[disp_rs1[i*RIDX_W +: RIDX_W]]),
      .older_valid(older_valid), .disp_rd(disp_rd), .disp_tag(disp_tag),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
      .commit_value(commit_value), .opnd(op1)
    );

    rename_operand_lookup #(
      .RIDX_W(RIDX_W), .TAG_W(TAG_W), .DATA_W(DATA_W),
      .DISP_W(DISP_W), .COMMIT_W(COMMIT_W)
    ) u_rs2 (
      .src(disp_rs2[i*RIDX_W +: RIDX_W]), .entry(regs[disp_rs2[i*RIDX_W +: RIDX_W]]),
      .older_valid(older_valid), .disp_rd(disp_rd), .disp_tag(disp_tag),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
      .commit_value(commit_value), .opnd(op2)
    );

    assign rs1_ready[i]                  = op1.ready;
    assign rs1_value[i*DATA_W +: DATA_W] = op1.value;
    assign rs1_tag[i*TAG_W +: TAG_W]     = op1.tag;
    assign rs2_ready[i]                  = op2.ready;
    assign rs2_value[i*DATA_W +: DATA_W] = op2.value;
    assign rs2_tag[i*TAG_W +: TAG_W]     = op2.tag;
  end

endmodule

// File: tb/tb_rename_regfile_mp.sv
// tb/tb_rename_regfile_mp.sv - randomized and directed bench for rename_regfile_mp against a rule-level model
module tb_rename_regfile_mp;

  localparam int NR = 32;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int RW = 5;
  localparam int DS = 2;
  localparam int CW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush;
  logic [DS-1:0]    disp_valid;
  logic [DS*RW-1:0] disp_rs1, disp_rs2, disp_rd;
  logic [DS*TW-1:0] disp_tag;
  logic [DS-1:0]    rs1_ready, rs2_ready;
  logic [DS*DW-1:0] rs1_value, rs2_value;
  logic [DS*TW-1:0] rs1_tag, rs2_tag;
  logic [CW-1:0]    commit_valid;
  logic [CW*RW-1:0] commit_rd;
  logic [CW*TW-1:0] commit_tag;
  logic [CW*DW-1:0] commit_value;
  logic [RW:0]      busy_count;

  rename_regfile_mp dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
    .disp_rd(disp_rd), .disp_tag(disp_tag),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_tag(commit_tag), .commit_value(commit_value),
    .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // architectural model state
  logic [DW-1:0] m_val  [NR];
  logic [TW-1:0] m_tag  [NR];
  logic          m_busy [NR];

  // stimulus for the current cycle
  logic          d_v   [DS];
  logic [RW-1:0] d_rs1 [DS];
  logic [RW-1:0] d_rs2 [DS];
  logic [RW-1:0] d_rd  [DS];
  logic [TW-1:0] d_tag [DS];
  logic          c_v   [CW];
  logic [RW-1:0] c_rd  [CW];
  logic [TW-1:0] c_tag [CW];
  logic [DW-1:0] c_val [CW];
  logic          f_v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_val[r] = '0; m_tag[r] = '0; m_busy[r] = 1'b0;
    end
  endtask

  task automatic clr();
    for (int i = 0; i < DS; i++) begin
      d_v[i] = 1'b0; d_rs1[i] = '0; d_rs2[i] = '0; d_rd[i] = '0; d_tag[i] = '0;
    end
    for (int k = 0; k < CW; k++) begin
      c_v[k] = 1'b0; c_rd[k] = '0; c_tag[k] = '0; c_val[k] = '0;
    end
    f_v = 1'b0;
  endtask

  task automatic apply();
    for (int i = 0; i < DS; i++) begin
      disp_valid[i]          = d_v[i];
      disp_rs1[i*RW +: RW]   = d_rs1[i];
      disp_rs2[i*RW +: RW]   = d_rs2[i];
      disp_rd[i*RW +: RW]    = d_rd[i];
      disp_tag[i*TW +: TW]   = d_tag[i];
    end
    for (int k = 0; k < CW; k++) begin
      commit_valid[k]          = c_v[k];
      commit_rd[k*RW +: RW]    = c_rd[k];
      commit_tag[k*TW +: TW]   = c_tag[k];
      commit_value[k*DW +: DW] = c_val[k];
    end
    flush = f_v;
  endtask

  // operand lookup written straight from the priority list of rules
  task automatic model_read(input int i, input logic [RW-1:0] s,
                            output logic rdy, output logic [DW-1:0] v, output logic [TW-1:0] t);
    rdy = 1'b1; v = '0; t = '0;
    if (s == 0) return;
    for (int j = i - 1; j >= 0; j--) begin
      if (d_v[j] && d_rd[j] == s) begin
        rdy = 1'b0; t = d_tag[j]; return;
      end
    end
    if (m_busy[s]) begin
      for (int k = 0; k < CW; k++) begin
        if (c_v[k] && c_rd[k] == s && c_tag[k] == m_tag[s]) begin
          v = c_val[k]; return;
        end
      end
      rdy = 1'b0; t = m_tag[s]; return;
    end
    v = m_val[s];
  endtask

  function automatic int model_count();
    int n = 0;
    for (int r = 0; r < NR; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  task automatic model_edge();
    logic ren [NR];
    for (int r = 0; r < NR; r++) ren[r] = 1'b0;
    for (int i = 0; i < DS; i++) if (d_v[i] && d_rd[i] != 0) ren[d_rd[i]] = 1'b1;
    for (int k = 0; k < CW; k++) begin
      if (c_v[k] && c_rd[k] != 0) begin
        m_val[c_rd[k]] = c_val[k];
        if (m_tag[c_rd[k]] == c_tag[k] && !ren[c_rd[k]]) m_busy[c_rd[k]] = 1'b0;
      end
    end
    if (f_v) begin
      for (int r = 0; r < NR; r++) begin
        m_busy[r] = 1'b0; m_tag[r] = '0;
      end
    end else begin
      for (int i = 0; i < DS; i++) begin
        if (d_v[i] && d_rd[i] != 0) begin
          m_tag[d_rd[i]] = d_tag[i]; m_busy[d_rd[i]] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_reads();
    logic          rdy;
    logic [DW-1:0] v;
    logic [TW-1:0] t;
    for (int i = 0; i < DS; i++) begin
      model_read(i, d_rs1[i], rdy, v, t);
      check("rs1_ready", 32'(rs1_ready[i]), 32'(rdy));
      check("rs1_value", rs1_value[i*DW +: DW], v);
      check("rs1_tag", 32'(rs1_tag[i*TW +: TW]), 32'(t));
      model_read(i, d_rs2[i], rdy, v, t);
      check("rs2_ready", 32'(rs2_ready[i]), 32'(rdy));
      check("rs2_value", rs2_value[i*DW +: DW], v);
      check("rs2_tag", 32'(rs2_tag[i*TW +: TW]), 32'(t));
    end
  endtask

  task automatic step();
    apply();
    #1;
    compare_reads();
    @(posedge clk);
    model_edge();
    #1;
    check("busy_count", 32'(busy_count), 32'(model_count()));
  endtask

  function automatic logic [RW-1:0] rnd_reg();
    if ($urandom_range(0, 3) == 0) return RW'($urandom_range(0, NR - 1));
    return RW'($urandom_range(0, 7));
  endfunction

  task automatic randomize_cycle();
    for (int i = 0; i < DS; i++) begin
      d_v[i] = 1'($urandom_range(0, 1));
      d_rs1[i] = rnd_reg(); d_rs2[i] = rnd_reg(); d_rd[i] = rnd_reg();
      d_tag[i] = TW'($urandom);
    end
    for (int k = 0; k < CW; k++) begin
      c_v[k] = 1'($urandom_range(0, 1));
      c_rd[k] = rnd_reg();
      c_tag[k] = ($urandom_range(0, 1) == 1) ? m_tag[c_rd[k]] : TW'($urandom);
      c_val[k] = $urandom;
    end
    // in-flight tags are unique, so two commits never both hit one producer
    if (c_rd[1] == c_rd[0] && c_tag[1] == c_tag[0]) c_tag[1] = c_tag[1] ^ 4'h1;
    f_v = ($urandom_range(0, 31) == 0);
  endtask

  initial begin
    model_reset();
    clr();
    apply();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy_count", 32'(busy_count), 32'd0);
    d_rs1[0] = 5; apply(); #1;
    check("rst_rs1_ready", 32'(rs1_ready[0]), 32'd1);
    check("rst_rs2_ready", 32'(rs2_ready[0]), 32'd1);
    check("rst_rs1_value", rs1_value[DW-1:0], 32'd0);
    check("rst_rs2_value", rs2_value[DW-1:0], 32'd0);
    rst_n = 1'b1;
    step();

    // rename then commit with bypass
    clr(); d_v[0] = 1; d_rd[0] = 3; d_tag[0] = 4; step();
    clr(); d_rs1[0] = 3; apply(); #1;
    check("ren_ready", 32'(rs1_ready[0]), 32'd0);
    check("ren_tag", 32'(rs1_tag[TW-1:0]), 32'd4);
    check("ren_count", 32'(busy_count), 32'd1);
    step();
    clr(); d_rs1[0] = 3; c_v[0] = 1; c_rd[0] = 3; c_tag[0] = 4; c_val[0] = 32'hDEAD;
    apply(); #1;
    check("byp_ready", 32'(rs1_ready[0]), 32'd1);
    check("byp_value", rs1_value[DW-1:0], 32'hDEAD);
    step();
    check("commit_count", 32'(busy_count), 32'd0);

    // intra-group dependency and duplicate rd
    clr(); d_v[0] = 1; d_rd[0] = 7; d_tag[0] = 2; d_rs1[1] = 7;
    d_v[1] = 1; d_rd[1] = 7; d_tag[1] = 3;
    apply(); #1;
    check("grp_ready", 32'(rs1_ready[1]), 32'd0);
    check("grp_tag", 32'(rs1_tag[2*TW-1:TW]), 32'd2);
    step();
    clr(); d_rs1[0] = 7; apply(); #1;
    check("dup_tag", 32'(rs1_tag[TW-1:0]), 32'd3);
    step();

    // stale commit leaves the newer rename in place
    clr(); d_v[0] = 1; d_rd[0] = 9; d_tag[0] = 1; step();
    clr(); d_v[0] = 1; d_rd[0] = 9; d_tag[0] = 6; step();
    clr(); c_v[0] = 1; c_rd[0] = 9; c_tag[0] = 1; c_val[0] = 32'h11; step();
    clr(); d_rs1[0] = 9; apply(); #1;
    check("stale_ready", 32'(rs1_ready[0]), 32'd0);
    check("stale_tag", 32'(rs1_tag[TW-1:0]), 32'd6);
    step();

    // commit and rename of the same rd in one cycle
    clr(); c_v[0] = 1; c_rd[0] = 9; c_tag[0] = 6; c_val[0] = 32'h99;
    d_v[0] = 1; d_rd[0] = 9; d_tag[0] = 8; step();
    clr(); d_rs1[0] = 9; apply(); #1;
    check("race_ready", 32'(rs1_ready[0]), 32'd0);
    check("race_tag", 32'(rs1_tag[TW-1:0]), 32'd8);
    step();

    // flush with several busy entries and a same-cycle commit
    clr(); d_v[0] = 1; d_rd[0] = 10; d_tag[0] = 9; d_v[1] = 1; d_rd[1] = 11; d_tag[1] = 10; step();
    clr(); d_v[0] = 1; d_rd[0] = 12; d_tag[0] = 11; d_v[1] = 1; d_rd[1] = 13; d_tag[1] = 12; step();
    clr(); f_v = 1; c_v[0] = 1; c_rd[0] = 2; c_tag[0] = 0; c_val[0] = 32'h55;
    d_v[0] = 1; d_rd[0] = 14; d_tag[0] = 13; step();
    check("flush_count", 32'(busy_count), 32'd0);
    clr(); d_rs1[0] = 2; d_rs2[0] = 9; apply(); #1;
    check("flush_val2", rs1_value[DW-1:0], 32'h55);
    check("flush_val9", rs2_value[DW-1:0], 32'h99);
    step();

    // random traffic with an asynchronous reset in the middle
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        clr(); d_v[0] = 1; d_rd[0] = 4; d_tag[0] = 5; step();
        #2 rst_n = 1'b0;
        model_reset();
        clr(); d_rs1[0] = 4; d_rs2[1] = 6; apply(); #1;
        check("arst_count", 32'(busy_count), 32'd0);
        compare_reads();
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      randomize_cycle();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
